// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - word-wide CPU data bus between the load/store unit and the memory controller
interface CpuDataInterface;
    logic [31:0] AddressBus;
    logic [31:0] DataWriteBus;
    logic        WriteAssert;
    logic [31:0] DataReadBus;
    logic        ReadOK;
    logic        WriteOK;

    modport cpu (
        output AddressBus, DataWriteBus, WriteAssert,
        input  DataReadBus, ReadOK, WriteOK
    );

    modport mem (
        input  AddressBus, DataWriteBus, WriteAssert,
        output DataReadBus, ReadOK, WriteOK
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word loads and stores mapped onto aligned 32-bit word accesses
module load_store_unit #(
    parameter int READ_LATENCY = 1
) (
    input  logic        CoreClock,
    input  logic        Reset_n,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [1:0]  ReqSize,
    input  logic        ReqSigned,
    input  logic [31:0] ReqAddress,
    input  logic [31:0] ReqWriteData,
    output logic        RespValid,
    output logic [31:0] RespData,
    output logic        RespError,
    CpuDataInterface.cpu memInterface
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [1:0] LAT = 2'(READ_LATENCY);

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic [1:0]  cnt_q, cnt_d;

    logic        accept;
    logic        req_err;
    logic        capture;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;
    logic [31:0] merged;

    always_comb begin
        accept  = ReqValid && (state_q == IDLE);
        req_err = (ReqSize == 2'b11)
               || ((ReqSize == 2'b01) && ReqAddress[0])
               || ((ReqSize == 2'b10) && (ReqAddress[1:0] != 2'b00));
        capture = (state_q == READ) && memInterface.ReadOK && (cnt_q == LAT);
    end

    // Little-endian lane extraction and sub-word merge against the captured word.
    always_comb begin
        rd_byte = memInterface.DataReadBus[{addr_q[1:0], 3'b000} +: 8];
        rd_half = addr_q[1] ? memInterface.DataReadBus[31:16] : memInterface.DataReadBus[15:0];
        case (size_q)
            2'b00:   load_val = {{24{signed_q & rd_byte[7]}}, rd_byte};
            2'b01:   load_val = {{16{signed_q & rd_half[15]}}, rd_half};
            default: load_val = memInterface.DataReadBus;
        endcase
        merged = memInterface.DataReadBus;
        if (size_q == 2'b00) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_ff @(posedge CoreClock) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_d = RESP;
                    end else if (ReqWrite && (ReqSize == 2'b10)) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ:    if (capture) state_d = write_q ? WRITE : RESP;
            WRITE:   if (memInterface.WriteOK) state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        write_d     = write_q;
        size_d      = size_q;
        signed_d    = signed_q;
        err_d       = err_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        resp_data_d = resp_data_q;
        cnt_d       = cnt_q;
        if (accept) begin
            write_d     = ReqWrite;
            size_d      = ReqSize;
            signed_d    = ReqSigned;
            err_d       = req_err;
            addr_d      = ReqAddress;
            wdata_d     = ReqWriteData;
            resp_data_d = 32'd0;
            cnt_d       = 2'd0;
        end else if (capture) begin
            if (write_q) begin
                wdata_d = merged;
            end else begin
                resp_data_d = load_val;
            end
        end else if ((state_q == READ) && memInterface.ReadOK) begin
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge CoreClock) begin
        if (!Reset_n) begin
            write_q     <= 1'b0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            resp_data_q <= 32'd0;
            cnt_q       <= 2'd0;
        end else begin
            write_q     <= write_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            resp_data_q <= resp_data_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        ReqReady                  = (state_q == IDLE);
        RespValid                 = (state_q == RESP);
        RespData                  = (state_q == RESP) ? resp_data_q : 32'd0;
        RespError                 = (state_q == RESP) && err_q;
        memInterface.AddressBus   = ((state_q == READ) || (state_q == WRITE)) ? {2'b00, addr_q[31:2]} : 32'd0;
        memInterface.DataWriteBus = (state_q == WRITE) ? wdata_q : 32'd0;
        memInterface.WriteAssert  = (state_q == WRITE);
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_error;
    logic [31:0] mem [0:15];

    int err_cnt = 0;
    int chk_cnt = 0;
    int lat;

    CpuDataInterface mif();

    always #5 clk = ~clk;

    assign mif.DataReadBus = mem[mif.AddressBus[3:0]];

    always @(posedge clk) begin
        if (mif.WriteAssert && mif.WriteOK) mem[mif.AddressBus[3:0]] <= mif.DataWriteBus;
    end

    load_store_unit #(.READ_LATENCY(1)) dut (
        .CoreClock    (clk),
        .Reset_n      (rst_n),
        .ReqValid     (req_valid),
        .ReqReady     (req_ready),
        .ReqWrite     (req_write),
        .ReqSize      (req_size),
        .ReqSigned    (req_signed),
        .ReqAddress   (req_addr),
        .ReqWriteData (req_wdata),
        .RespValid    (resp_valid),
        .RespData     (resp_data),
        .RespError    (resp_error),
        .memInterface (mif)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = d;
        step();
        req_valid  = 1'b0;
    endtask

    task automatic wait_resp(input string tag, output int n);
        n = 1;
        while (!resp_valid && n < 20) begin
            step();
            n++;
        end
        if (!resp_valid) check({tag, " timeout"}, 32'd0, 32'd1);
    endtask

    task automatic full(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
        int n;
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        send(w, sz, sg, a, d);
        wait_resp(tag, n);
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " data"}, resp_data, exp_data);
        check({tag, " error"}, 32'(resp_error), 32'(exp_err));
        step();
        check({tag, " single strobe"}, 32'(resp_valid), 32'd0);
        check({tag, " ready again"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_size    = 2'b00;
        req_signed  = 1'b0;
        req_addr    = 32'd0;
        req_wdata   = 32'd0;
        mif.ReadOK  = 1'b1;
        mif.WriteOK = 1'b1;
        step();
        step();
        check("rst ready", 32'(req_ready), 32'd1);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst resp_data", resp_data, 32'd0);
        check("rst resp_error", 32'(resp_error), 32'd0);
        check("rst addr", mif.AddressBus, 32'd0);
        check("rst wdata", mif.DataWriteBus, 32'd0);
        check("rst wassert", 32'(mif.WriteAssert), 32'd0);
        rst_n = 1'b1;
        step();

        send(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        check("wst T1 wassert", 32'(mif.WriteAssert), 32'd1);
        check("wst T1 addr", mif.AddressBus, 32'h4);
        check("wst T1 wdata", mif.DataWriteBus, 32'hDEADBEEF);
        check("wst T1 rv", 32'(resp_valid), 32'd0);
        step();
        check("wst T2 rv", 32'(resp_valid), 32'd1);
        check("wst T2 err", 32'(resp_error), 32'd0);
        check("wst T2 wassert", 32'(mif.WriteAssert), 32'd0);
        step();
        check("wst T3 ready", 32'(req_ready), 32'd1);
        check("wst mem", mem[4], 32'hDEADBEEF);

        send(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000A5);
        check("bst T1 addr", mif.AddressBus, 32'h4);
        check("bst T1 wassert", 32'(mif.WriteAssert), 32'd0);
        step();
        check("bst T2 wassert", 32'(mif.WriteAssert), 32'd0);
        step();
        check("bst T3 wassert", 32'(mif.WriteAssert), 32'd1);
        check("bst T3 wdata", mif.DataWriteBus, 32'hDEADA5EF);
        check("bst T3 addr", mif.AddressBus, 32'h4);
        step();
        check("bst T4 rv", 32'(resp_valid), 32'd1);
        check("bst T4 data", resp_data, 32'd0);
        step();
        check("bst mem", mem[4], 32'hDEADA5EF);

        full("wst2", 1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF0000, 32'd0, 1'b0, 2);
        full("lb s 13", 1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 32'hFFFFFF80, 1'b0, 3);
        full("lb u 13", 1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 32'h00000080, 1'b0, 3);
        full("lh s 12", 1'b0, 2'b01, 1'b1, 32'h12, 32'd0, 32'hFFFF80FF, 1'b0, 3);
        full("lh u 12", 1'b0, 2'b01, 1'b0, 32'h12, 32'd0, 32'h000080FF, 1'b0, 3);
        full("lb s 12", 1'b0, 2'b00, 1'b1, 32'h12, 32'd0, 32'hFFFFFFFF, 1'b0, 3);
        full("lh s 10", 1'b0, 2'b01, 1'b1, 32'h10, 32'd0, 32'h00000000, 1'b0, 3);
        full("lw 10", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'h80FF0000, 1'b0, 3);
        full("sh 12", 1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234, 32'd0, 1'b0, 4);
        full("lw after sh", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'h12340000, 1'b0, 3);

        send(1'b0, 2'b10, 1'b0, 32'h6, 32'd0);
        check("mis T1 rv", 32'(resp_valid), 32'd1);
        check("mis T1 err", 32'(resp_error), 32'd1);
        check("mis T1 data", resp_data, 32'd0);
        check("mis T1 wassert", 32'(mif.WriteAssert), 32'd0);
        check("mis T1 addr", mif.AddressBus, 32'd0);
        step();
        check("mis T2 ready", 32'(req_ready), 32'd1);
        check("mis T2 rv", 32'(resp_valid), 32'd0);
        check("mis T2 addr", mif.AddressBus, 32'd0);
        full("size 11", 1'b0, 2'b11, 1'b0, 32'h10, 32'd0, 32'd0, 1'b1, 1);
        full("lh odd", 1'b0, 2'b01, 1'b0, 32'h11, 32'd0, 32'd0, 1'b1, 1);
        full("sw mis", 1'b1, 2'b10, 1'b0, 32'h12, 32'h55555555, 32'd0, 1'b1, 1);
        check("sw mis no write", mem[4], 32'h12340000);

        mif.WriteOK = 1'b0;
        send(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D);
        for (int i = 0; i < 3; i++) begin
            check("wstall wassert", 32'(mif.WriteAssert), 32'd1);
            check("wstall addr", mif.AddressBus, 32'h8);
            check("wstall wdata", mif.DataWriteBus, 32'hCAFEF00D);
            check("wstall rv", 32'(resp_valid), 32'd0);
            step();
        end
        mif.WriteOK = 1'b1;
        check("wstall ok wassert", 32'(mif.WriteAssert), 32'd1);
        check("wstall ok rv", 32'(resp_valid), 32'd0);
        step();
        check("wstall rv", 32'(resp_valid), 32'd1);
        check("wstall mem", mem[8], 32'hCAFEF00D);
        step();

        mif.ReadOK = 1'b0;
        send(1'b0, 2'b10, 1'b0, 32'h20, 32'd0);
        check("rstall T1 addr", mif.AddressBus, 32'h8);
        check("rstall T1 rv", 32'(resp_valid), 32'd0);
        step();
        check("rstall T2 addr", mif.AddressBus, 32'h8);
        step();
        mif.ReadOK = 1'b1;
        check("rstall T3 addr", mif.AddressBus, 32'h8);
        step();
        check("rstall T4 rv", 32'(resp_valid), 32'd0);
        step();
        check("rstall T5 rv", 32'(resp_valid), 32'd1);
        check("rstall T5 data", resp_data, 32'hCAFEF00D);
        step();

        send(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
        check("rst rd T1 addr", mif.AddressBus, 32'h4);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst rd ready", 32'(req_ready), 32'd1);
        check("rst rd rv", 32'(resp_valid), 32'd0);
        check("rst rd addr", mif.AddressBus, 32'd0);
        step();
        check("rst rd rv later", 32'(resp_valid), 32'd0);
        full("lw after rst", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'h12340000, 1'b0, 3);

        mif.WriteOK = 1'b0;
        send(1'b1, 2'b10, 1'b0, 32'h24, 32'h11111111);
        check("rst wr T1 wassert", 32'(mif.WriteAssert), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        mif.WriteOK = 1'b1;
        check("rst wr wassert", 32'(mif.WriteAssert), 32'd0);
        check("rst wr rv", 32'(resp_valid), 32'd0);
        step();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the CPU execute stage and the `CpuDataInterface` that feeds the first memory controller. Turns CPU byte/halfword/word loads and stores into aligned 32-bit word accesses on that interface. Sub-word stores use read-modify-write; loads are extracted and sign- or zero-extended. The block honours the ReadOK/WriteOK handshakes, so memory back-ends with wait states can later replace the zero-wait controller without CPU changes.

## Interface

Parameters:
- READ_LATENCY, default 1: cycles from the first ReadOK=1 cycle (address held) until DataReadBus is valid. Legal range 0..3.

Ports:
- CoreClock  in  1  core clock; all logic on its rising edge
- Reset_n  in  1  synchronous reset, active-low
- ReqValid  in  1  CPU request valid
- ReqReady  out  1  block can accept a request; high only in IDLE
- ReqWrite  in  1  1 = store, 0 = load
- ReqSize  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- ReqSigned  in  1  loads only: sign-extend when 1
- ReqAddress  in  32  byte address
- ReqWriteData  in  32  store data, right-justified
- RespValid  out  1  one-cycle response strobe
- RespData  out  32  load result; 0 for stores and errors
- RespError  out  1  request was misaligned or illegal; valid with RespValid
- memInterface  interface  CpuDataInterface  this block drives AddressBus, DataWriteBus and WriteAssert; it samples DataReadBus, ReadOK and WriteOK

## Operation

- Request accept: on ReqValid && ReqReady, latch write, size, signed, address and write data.
- Error check at accept:
  - Size 11 is an error.
  - Halfword with address[0]=1 is an error.
  - Word with address[1:0]≠0 is an error.
  - On error, go straight to RESP with RespError=1. No memory access takes place.
- Word address: AddressBus = {2'b00, address[31:2]}. Byte lanes are little-endian; lane = address[1:0].
- States: IDLE, READ, WRITE, RESP.
  - IDLE → RESP on an error.
  - IDLE → WRITE on a word store.
  - IDLE → READ on a load or a sub-word store.
  - READ → RESP (load) or → WRITE (sub-word store) once data is captured.
  - WRITE → RESP on WriteOK=1.
  - RESP → IDLE unconditionally.
- READ:
  - Hold AddressBus.
  - A 2-bit counter starts on the first cycle with ReadOK=1.
  - Capture DataReadBus in the cycle the counter equals READ_LATENCY. For READ_LATENCY=0 that is the ReadOK cycle itself.
  - While ReadOK=0 the counter does not advance.
- Load extraction:
  - Byte: select lane address[1:0].
  - Half: select bits [31:16] if address[1] else [15:0].
  - Then extend to 32 bits with the sign bit when ReqSigned=1, otherwise with zeros.
- Sub-word store merge: replace only the addressed byte or halfword of the captured word with ReqWriteData[7:0] or [15:0]. All other bits are unchanged.
- WRITE:
  - WriteAssert=1.
  - DataWriteBus = merged word, or ReqWriteData for a word store.
  - AddressBus is held.
  - Everything stays stable until WriteOK=1 is sampled.
- Outputs outside their active states:
  - AddressBus = 0 in IDLE and RESP.
  - DataWriteBus = 0 and WriteAssert = 0 outside WRITE.
- Reset values: state IDLE, ReqReady=1, RespValid=0, RespData=0, RespError=0, AddressBus=0, DataWriteBus=0, WriteAssert=0.
- Reset mid-operation: the in-flight request is dropped with no RespValid. WriteAssert falls on the reset edge.

## Timing

- Example sequences assume ReadOK=WriteOK=1, READ_LATENCY=1, and accept in cycle T0.
- Error: RespValid in T1; ReqReady high again in T2.
- Word store: WriteAssert in T1, RespValid in T2.
- Load: address driven T1–T2, data captured T2, RespValid T3.
- Sub-word store: read T1–T2, WriteAssert T3, RespValid T4.
- Each cycle of ReadOK=0 or WriteOK=0 adds exactly one cycle.
- At most one request is in flight. ReqValid outside IDLE is ignored.
- RespValid is never high for more than one cycle per request.

## Test plan

- Word store, address 0x10, data 0xDEADBEEF → T1: WriteAssert=1, AddressBus=0x4, DataWriteBus=0xDEADBEEF. T2: RespValid=1, RespError=0.
- Byte store of 0xA5 to address 0x11, memory word 4 = 0xDEADBEEF → one read, then WriteAssert with DataWriteBus=0xDEADA5EF, then RespValid.
- Memory word 4 = 0x80FF0000:
  - Signed byte load at 0x13 → RespData=0xFFFFFF80.
  - Unsigned byte load at 0x13 → 0x00000080.
  - Signed half load at 0x12 → 0xFFFF80FF.
- Misaligned word load at 0x6 → RespValid in T1 with RespError=1 and RespData=0. WriteAssert and AddressBus stay 0 throughout.
- Word store with WriteOK held 0 for 3 cycles → WriteAssert, AddressBus and DataWriteBus all held stable. RespValid comes one cycle after WriteOK=1. Repeat the stall test for a load using ReadOK=0 for 2 cycles.
- Reset_n=0 for one cycle while in READ → next cycle IDLE, ReqReady=1, no RespValid. A following word load completes normally.
